// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM march-test controller.
// The word function is width-agnostic; callers cast to their own data width.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrBg,
    StRdUp,
    StWrInv,
    StRdDn,
    StDone
  } bist_state_e;

  // Cycles spent after the last read issue so the compare pipeline empties
  localparam int unsigned DrainCycles = 2;
  localparam int unsigned ReadLatency = 2;
  localparam int unsigned MaxWidth    = 64;

  // Background word for an address: pattern xor the zero-extended address
  function automatic logic [MaxWidth-1:0] word_fn(input logic [MaxWidth-1:0] pattern,
                                                  input logic [MaxWidth-1:0] addr);
    return pattern ^ addr;
  endfunction

  // Busy length of one complete run for a given address width
  function automatic int unsigned run_cycles(input int unsigned a_width);
    return 4 * (1 << a_width) + 2 * DrainCycles;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Expected-data pipeline aligned to the RAM read latency, compare, first-fail capture
// and saturating mismatch counter.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 16,
  parameter int unsigned A_WIDTH   = 5,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 issue_valid_i,
  input  logic [A_WIDTH-1:0]   issue_addr_i,
  input  logic [D_WIDTH-1:0]   issue_exp_i,
  input  logic [D_WIDTH-1:0]   rdata_i,
  output logic                 fail_o,
  output logic [A_WIDTH-1:0]   fail_addr_o,
  output logic [D_WIDTH-1:0]   fail_expected_o,
  output logic [D_WIDTH-1:0]   fail_data_o,
  output logic [CNT_WIDTH-1:0] err_count_o
);

  // Stage 0 lines up with the address on the RAM read port, stage 1 with data_read
  logic [ReadLatency-1:0] valid_q;
  logic [A_WIDTH-1:0]     addr_q [ReadLatency];
  logic [D_WIDTH-1:0]     exp_q  [ReadLatency];

  logic                 fail_q;
  logic [A_WIDTH-1:0]   fail_addr_q;
  logic [D_WIDTH-1:0]   fail_expected_q;
  logic [D_WIDTH-1:0]   fail_data_q;
  logic [CNT_WIDTH-1:0] err_count_q;

  logic mismatch;
  assign mismatch = valid_q[1] && (rdata_i != exp_q[1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q         <= '0;
      addr_q[0]       <= '0;
      addr_q[1]       <= '0;
      exp_q[0]        <= '0;
      exp_q[1]        <= '0;
      fail_q          <= 1'b0;
      fail_addr_q     <= '0;
      fail_expected_q <= '0;
      fail_data_q     <= '0;
      err_count_q     <= '0;
    end else begin
      valid_q   <= {valid_q[0], issue_valid_i};
      addr_q[0] <= issue_addr_i;
      addr_q[1] <= addr_q[0];
      exp_q[0]  <= issue_exp_i;
      exp_q[1]  <= exp_q[0];
      if (clear_i) begin
        fail_q          <= 1'b0;
        fail_addr_q     <= '0;
        fail_expected_q <= '0;
        fail_data_q     <= '0;
        err_count_q     <= '0;
      end else if (mismatch) begin
        if (err_count_q != '1) begin
          err_count_q <= err_count_q + 1'b1;
        end
        if (!fail_q) begin
          fail_q          <= 1'b1;
          fail_addr_q     <= addr_q[1];
          fail_expected_q <= exp_q[1];
          fail_data_q     <= rdata_i;
        end
      end
    end
  end

  assign fail_o          = fail_q;
  assign fail_addr_o     = fail_addr_q;
  assign fail_expected_o = fail_expected_q;
  assign fail_data_o     = fail_data_q;
  assign err_count_o     = err_count_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator for the simple dual-port RAM: write background, read up,
// write inverse, read down; results reported through the checker.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned         D_WIDTH   = 16,
  parameter int unsigned         A_WIDTH   = 5,
  parameter logic [D_WIDTH-1:0]  PATTERN   = 16'hA5A5,
  parameter int unsigned         CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [A_WIDTH-1:0]   fail_addr,
  output logic [D_WIDTH-1:0]   fail_expected,
  output logic [D_WIDTH-1:0]   fail_data,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [A_WIDTH-1:0]   address_write,
  output logic [D_WIDTH-1:0]   data_write,
  output logic                 write_enable,
  output logic [A_WIDTH-1:0]   address_read,
  input  logic [D_WIDTH-1:0]   data_read
);

  localparam logic [A_WIDTH-1:0] LastAddr = '1;
  localparam logic [1:0]         LastDrain = 2'(DrainCycles);

  function automatic logic [D_WIDTH-1:0] w_of(input logic [A_WIDTH-1:0] a);
    return D_WIDTH'(word_fn(MaxWidth'(PATTERN), MaxWidth'(a)));
  endfunction

  bist_state_e        state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]         drain_q, drain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               we_q, we_d;
  logic [A_WIDTH-1:0] aw_q, aw_d;
  logic [D_WIDTH-1:0] dw_q, dw_d;
  logic [A_WIDTH-1:0] ar_q, ar_d;

  // Issue info is produced for the cycle in which ar_d becomes visible on address_read
  logic               issue_valid_d;
  logic [D_WIDTH-1:0] issue_exp_d;
  logic               clear_d;

  logic [A_WIDTH-1:0] cnt_inc;
  logic [A_WIDTH-1:0] cnt_dec;
  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_dec = cnt_q - 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    busy_d        = busy_q;
    done_d        = done_q;
    we_d          = 1'b0;
    aw_d          = aw_q;
    dw_d          = dw_q;
    ar_d          = ar_q;
    issue_valid_d = 1'b0;
    issue_exp_d   = '0;
    clear_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrBg;
          cnt_d   = '0;
          drain_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          clear_d = 1'b1;
          we_d    = 1'b1;
          aw_d    = '0;
          dw_d    = w_of('0);
        end
      end

      StWrBg: begin
        if (cnt_q == LastAddr) begin
          state_d       = StRdUp;
          cnt_d         = '0;
          ar_d          = '0;
          issue_valid_d = 1'b1;
          issue_exp_d   = w_of('0);
        end else begin
          cnt_d = cnt_inc;
          we_d  = 1'b1;
          aw_d  = cnt_inc;
          dw_d  = w_of(cnt_inc);
        end
      end

      StRdUp: begin
        if (drain_q != '0) begin
          if (drain_q == LastDrain) begin
            state_d = StWrInv;
            drain_d = '0;
            cnt_d   = '0;
            we_d    = 1'b1;
            aw_d    = '0;
            dw_d    = ~w_of('0);
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end else if (cnt_q == LastAddr) begin
          drain_d = 2'd1;
        end else begin
          cnt_d         = cnt_inc;
          ar_d          = cnt_inc;
          issue_valid_d = 1'b1;
          issue_exp_d   = w_of(cnt_inc);
        end
      end

      StWrInv: begin
        if (cnt_q == LastAddr) begin
          state_d       = StRdDn;
          cnt_d         = LastAddr;
          ar_d          = LastAddr;
          issue_valid_d = 1'b1;
          issue_exp_d   = ~w_of(LastAddr);
        end else begin
          cnt_d = cnt_inc;
          we_d  = 1'b1;
          aw_d  = cnt_inc;
          dw_d  = ~w_of(cnt_inc);
        end
      end

      StRdDn: begin
        if (drain_q != '0) begin
          if (drain_q == LastDrain) begin
            state_d = StDone;
            drain_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end else if (cnt_q == '0) begin
          drain_d = 2'd1;
        end else begin
          cnt_d         = cnt_dec;
          ar_d          = cnt_dec;
          issue_valid_d = 1'b1;
          issue_exp_d   = ~w_of(cnt_dec);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      aw_q    <= '0;
      dw_q    <= '0;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      aw_q    <= aw_d;
      dw_q    <= dw_d;
      ar_q    <= ar_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign write_enable  = we_q;
  assign address_write = aw_q;
  assign data_write    = dw_q;
  assign address_read  = ar_q;

  ram_bist_checker #(
    .D_WIDTH   (D_WIDTH),
    .A_WIDTH   (A_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_checker (
    .clk_i           (CLK),
    .rst_i           (RST),
    .clear_i         (clear_d),
    .issue_valid_i   (issue_valid_d),
    .issue_addr_i    (ar_d),
    .issue_exp_i     (issue_exp_d),
    .rdata_i         (data_read),
    .fail_o          (fail),
    .fail_addr_o     (fail_addr),
    .fail_expected_o (fail_expected),
    .fail_data_o     (fail_data),
    .err_count_o     (err_count)
  );

endmodule
